// File: rtl/flag_cdc_arbiter_pkg.sv
// ============================================================================
// flag_arb_pkg : FSM state type and round-robin pick helper for flag_cdc_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package flag_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  // First asserted index strictly after ptr, wrapping at n; returns ptr when nothing is set.
  function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  req,
                                                  input logic [MAX_ID_W-1:0] ptr,
                                                  input int                  n);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i <= n) && req[idx[MAX_ID_W-1:0]]) begin
        rr_pick = idx[MAX_ID_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/flag_cdc_arbiter_if.sv
// ============================================================================
// flag_cdc_arbiter_if : requester/completion bundle around the shared flag crossing
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface flag_cdc_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             flag_o;
  logic [ID_W-1:0]  id_o;
  logic             busy;
  logic             done_i;
  logic             timeout_o;

  modport master (
    output req, done_i,
    input  gnt, flag_o, id_o, busy, timeout_o
  );

  modport slave (
    input  req, done_i,
    output gnt, flag_o, id_o, busy, timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/flag_cdc_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin winner selection with an enabled pointer register
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import flag_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [ID_W-1:0]  pick,
  output logic             any
);

  logic [ID_W-1:0]     ptr;
  logic [MAX_REQ-1:0]  req_ext;
  logic [MAX_ID_W-1:0] ptr_ext;
  logic [MAX_ID_W-1:0] pick_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    ptr_ext              = '0;
    ptr_ext[ID_W-1:0]    = ptr;
    pick_ext             = rr_pick(req_ext, ptr_ext, N_REQ);
  end

  assign pick = pick_ext[ID_W-1:0];
  assign any  = |req;

  generate
    if (ID_W < MAX_ID_W) begin : g_pick_pad
      logic unused_pick_hi;
      assign unused_pick_hi = ^pick_ext[MAX_ID_W-1:ID_W];
    end
  endgenerate

  // Pointer starts at the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= ID_W'(N_REQ - 1);
    else if (en) ptr <= pick;
  end

endmodule

`default_nettype wire

// File: rtl/flag_cdc_arbiter.sv
// ============================================================================
// flag_cdc_arbiter : shares one flag_cdc pulse crossing among N_REQ requesters
//                    Optional watchdog: define FLAG_ARB_TIMEOUT_EN
// Revision         : 1.0
// ============================================================================
`default_nettype none

module flag_cdc_arbiter
  import flag_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  flag_cdc_arbiter_if.slave  bus
);

  localparam int              ID_W     = $clog2(N_REQ);
  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [ID_W-1:0]  pick;
  logic             any_req;
  logic             grant_en;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;
  logic             expire;

  logic [N_REQ-1:0] gnt_q,  gnt_nxt;
  logic             flag_q, flag_nxt;
  logic [ID_W-1:0]  id_q,   id_nxt;
  logic             busy_q, busy_nxt;
  logic             tmo_q,  tmo_nxt;

  assign grant_en = (state == IDLE) && any_req;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.req),
    .en   (grant_en),
    .pick (pick),
    .any  (any_req)
  );

  // Reloaded every WAIT_DONE cycle so GAP always begins with a full count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   gap_cnt <= '0;
    else if (state == WAIT_DONE)               gap_cnt <= GAP_LOAD;
    else if ((state == GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - 1'b1;
  end

  assign gap_done = (gap_cnt == '0);

`ifdef FLAG_ARB_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wd_cnt <= '0;
    else if (state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
    else                         wd_cnt <= '0;
  end

  // A done_i arriving on the expiry cycle takes precedence over the watchdog.
  assign expire = (state == WAIT_DONE) && !bus.done_i && (wd_cnt == WD_LAST);
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = PULSE;
      PULSE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.done_i || expire) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt  = '0;
    flag_nxt = 1'b0;
    id_nxt   = id_q;
    busy_nxt = (state_nxt != IDLE);
    tmo_nxt  = expire;
    if (grant_en) begin
      gnt_nxt[pick] = 1'b1;
      flag_nxt      = 1'b1;
      id_nxt        = pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      flag_q <= 1'b0;
      id_q   <= '0;
      busy_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_nxt;
      flag_q <= flag_nxt;
      id_q   <= id_nxt;
      busy_q <= busy_nxt;
      tmo_q  <= tmo_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.flag_o    = flag_q;
  assign bus.id_o      = id_q;
  assign bus.busy      = busy_q;
  assign bus.timeout_o = tmo_q;

endmodule

`default_nettype wire
